// File: rtl/ds_link_pkg.sv
// ds_link_pkg -- shared definitions for the differential link direction
// controller and its receive deserializer.
//   - Controller state encodings (RX, TURN_TX, TX_HOLD, TX_SHIFT, TURN_RX)
//   - Line levels: LINE_IDLE (0) and START_BIT (1)
//   - even_parity(): even-parity bit over a zero-extended word (up to 64 bits)
// Optional feature macro: DS_LINK_PARITY_EN (used by the importing modules).
package ds_link_pkg;

    localparam logic [2:0] RX       = 3'd0;
    localparam logic [2:0] TURN_TX  = 3'd1;
    localparam logic [2:0] TX_HOLD  = 3'd2;
    localparam logic [2:0] TX_SHIFT = 3'd3;
    localparam logic [2:0] TURN_RX  = 3'd4;

    localparam logic LINE_IDLE = 1'b0;
    localparam logic START_BIT = 1'b1;

    // Even parity: the returned bit makes the total count of ones even.
    // Callers zero-extend narrower words, which does not change the result.
    function automatic logic even_parity(input logic [63:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ds_link_rx_deser.sv
// ds_link_rx_deser -- serial frame receiver for the differential link.
// Waits for a START_BIT while idle, then shifts in WIDTH data bits LSB first
// (plus one even-parity bit when DS_LINK_PARITY_EN is defined) and delivers
// the word with a one-cycle rx_valid pulse in the cycle after the last sample.
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   sample_en  input buffer is enabled; din is meaningful only when high
//   din        serial input from the pad receiver
//   busy       frame in progress, or a start bit is being sampled right now
//   rx_data    last received word (registered)
//   rx_valid   one-cycle pulse, rx_data is new (registered)
//   rx_perr    parity mismatch, valid with rx_valid (DS_LINK_PARITY_EN only)
module ds_link_rx_deser
    import ds_link_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic             din,
    output logic             busy,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid
`ifdef DS_LINK_PARITY_EN
    ,
    output logic             rx_perr
`endif
);

`ifdef DS_LINK_PARITY_EN
    localparam int DATA_BITS = WIDTH + 1;
`else
    localparam int DATA_BITS = WIDTH;
`endif
    // The final sample is used directly, so the shift register holds one bit
    // less than the number of samples following the start bit.
    localparam int SH_W  = DATA_BITS - 1;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_BITS - 1);

    logic             busy_r;
    logic [CNT_W-1:0] cnt_r;
    logic [SH_W-1:0]  shift_r;
    logic [WIDTH-1:0] rx_data_r;
    logic             rx_valid_r;
    logic             start_s;
`ifdef DS_LINK_PARITY_EN
    logic             rx_perr_r;
`endif

    assign start_s = sample_en & ~busy_r & (din == START_BIT);
    // Includes the start-sample cycle so the controller cannot turn the bus
    // around on the same edge that a frame begins.
    assign busy    = busy_r | start_s;

    // Frame capture: start detect, data shift and word delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r     <= 1'b0;
            cnt_r      <= {CNT_W{1'b0}};
            shift_r    <= {SH_W{1'b0}};
            rx_data_r  <= {WIDTH{1'b0}};
            rx_valid_r <= 1'b0;
`ifdef DS_LINK_PARITY_EN
            rx_perr_r  <= 1'b0;
`endif
        end else begin
            rx_valid_r <= 1'b0;
            if (sample_en && busy_r) begin
                if (cnt_r == LAST_IDX) begin
                    busy_r     <= 1'b0;
                    cnt_r      <= {CNT_W{1'b0}};
                    rx_valid_r <= 1'b1;
`ifdef DS_LINK_PARITY_EN
                    rx_data_r  <= shift_r;
                    rx_perr_r  <= even_parity(64'(shift_r)) ^ din;
`else
                    rx_data_r  <= {din, shift_r};
`endif
                end else begin
                    cnt_r   <= cnt_r + CNT_W'(1);
                    shift_r <= {din, shift_r[SH_W-1:1]};
                end
            end else if (start_s) begin
                busy_r <= 1'b1;
                cnt_r  <= {CNT_W{1'b0}};
            end
        end
    end

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
`ifdef DS_LINK_PARITY_EN
    assign rx_perr  = rx_perr_r;
`endif

endmodule

// File: rtl/ds_link_dir_ctrl.sv
// ds_link_dir_ctrl -- half-duplex direction controller and bit framer for one
// differential pad pair (I_BUF_DS with enable, O_BUFT_DS with tristate).
// Listens by default; on a TX request it turns the bus around (both buffers
// off for TURN_CYCLES), accepts and serializes words (start bit + WIDTH bits,
// LSB first), and returns to receive after IDLE_TIMEOUT idle cycles.
// Optional feature macro: DS_LINK_PARITY_EN adds an even-parity bit per frame
// in both directions and the rx_perr output.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   tx_data/tx_valid  word to send, held until accepted
//   tx_ready          word accepted when tx_valid && tx_ready
//   rx_data/rx_valid  received word and its one-cycle strobe
//   rx_perr           received parity mismatch (DS_LINK_PARITY_EN only)
//   ibuf_en, ibuf_o   I_BUF_DS enable and serial output
//   obuf_t, obuf_i    O_BUFT_DS drive enable (1 = driven) and serial input
module ds_link_dir_ctrl
    import ds_link_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int TURN_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
`ifdef DS_LINK_PARITY_EN
    output logic             rx_perr,
`endif
    output logic             ibuf_en,
    input  logic             ibuf_o,
    output logic             obuf_t,
    output logic             obuf_i
);

`ifdef DS_LINK_PARITY_EN
    localparam int DATA_BITS = WIDTH + 1;
`else
    localparam int DATA_BITS = WIDTH;
`endif
    localparam int BIT_W = $clog2(WIDTH + 2);
    localparam logic [3:0]       TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [7:0]       IDLE_LAST = 8'(IDLE_TIMEOUT - 1);
    localparam logic [BIT_W-1:0] TX_LAST   = BIT_W'(DATA_BITS);

    logic [2:0]       state_r;
    logic [2:0]       state_nxt_s;
    logic [3:0]       turn_cnt_r;
    logic [7:0]       idle_cnt_r;
    logic [BIT_W-1:0] bit_cnt_r;
    logic [WIDTH-1:0] tx_shift_r;
    logic             ibuf_en_r;
    logic             obuf_t_r;
    logic             obuf_i_r;
    logic             tx_ready_r;
    logic             accept_s;
    logic             rx_busy_s;
`ifdef DS_LINK_PARITY_EN
    logic             tx_par_r;
    localparam logic [BIT_W-1:0] PAR_IDX = BIT_W'(WIDTH);
`endif

    assign accept_s = tx_valid & tx_ready_r;

    // Next-state selection; an accept outranks the idle timeout.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            RX: begin
                if (tx_valid && !rx_busy_s) state_nxt_s = TURN_TX;
                else                        state_nxt_s = RX;
            end
            TURN_TX: begin
                if (turn_cnt_r == TURN_LAST) state_nxt_s = TX_HOLD;
                else                         state_nxt_s = TURN_TX;
            end
            TX_HOLD: begin
                if (accept_s)                     state_nxt_s = TX_SHIFT;
                else if (idle_cnt_r == IDLE_LAST) state_nxt_s = TURN_RX;
                else                              state_nxt_s = TX_HOLD;
            end
            TX_SHIFT: begin
                if (bit_cnt_r == TX_LAST) state_nxt_s = TX_HOLD;
                else                      state_nxt_s = TX_SHIFT;
            end
            TURN_RX: begin
                if (turn_cnt_r == TURN_LAST) state_nxt_s = RX;
                else                         state_nxt_s = TURN_RX;
            end
            default: state_nxt_s = RX;
        endcase
    end

    // State, counters, buffer controls and serializer. Buffer enables are
    // decoded from the next state so both are registered together and can
    // never be high in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= RX;
            turn_cnt_r <= 4'd0;
            idle_cnt_r <= 8'd0;
            bit_cnt_r  <= {BIT_W{1'b0}};
            tx_shift_r <= {WIDTH{1'b0}};
            ibuf_en_r  <= 1'b1;
            obuf_t_r   <= 1'b0;
            obuf_i_r   <= LINE_IDLE;
            tx_ready_r <= 1'b0;
`ifdef DS_LINK_PARITY_EN
            tx_par_r   <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt_s;
            ibuf_en_r  <= (state_nxt_s == RX);
            obuf_t_r   <= (state_nxt_s == TX_HOLD) || (state_nxt_s == TX_SHIFT);
            tx_ready_r <= (state_nxt_s == TX_HOLD);

            if (((state_r == TURN_TX) || (state_r == TURN_RX)) && (state_nxt_s == state_r))
                turn_cnt_r <= turn_cnt_r + 4'd1;
            else
                turn_cnt_r <= 4'd0;

            if ((state_r == TX_HOLD) && (state_nxt_s == TX_HOLD))
                idle_cnt_r <= idle_cnt_r + 8'd1;
            else
                idle_cnt_r <= 8'd0;

            if (accept_s) begin
                // Start bit goes out in the cycle right after the accept.
                tx_shift_r <= tx_data;
                bit_cnt_r  <= {BIT_W{1'b0}};
                obuf_i_r   <= START_BIT;
`ifdef DS_LINK_PARITY_EN
                tx_par_r   <= even_parity(64'(tx_data));
`endif
            end else if ((state_r == TX_SHIFT) && (state_nxt_s == TX_SHIFT)) begin
                bit_cnt_r  <= bit_cnt_r + BIT_W'(1);
                tx_shift_r <= {1'b0, tx_shift_r[WIDTH-1:1]};
`ifdef DS_LINK_PARITY_EN
                if (bit_cnt_r == PAR_IDX) obuf_i_r <= tx_par_r;
                else                      obuf_i_r <= tx_shift_r[0];
`else
                obuf_i_r   <= tx_shift_r[0];
`endif
            end else begin
                obuf_i_r   <= LINE_IDLE;
            end
        end
    end

    ds_link_rx_deser #(
        .WIDTH(WIDTH)
    ) u_rx_deser (
        .clk      (clk),
        .rst      (rst),
        .sample_en(ibuf_en_r),
        .din      (ibuf_o),
        .busy     (rx_busy_s),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`ifdef DS_LINK_PARITY_EN
        ,
        .rx_perr  (rx_perr)
`endif
    );

    assign ibuf_en  = ibuf_en_r;
    assign obuf_t   = obuf_t_r;
    assign obuf_i   = obuf_i_r;
    assign tx_ready = tx_ready_r;

endmodule

// File: tb/tb_ds_link_dir_ctrl.sv
// tb_ds_link_dir_ctrl -- directed self-checking bench for ds_link_dir_ctrl
// with default parameters (WIDTH=8, TURN_CYCLES=2, IDLE_TIMEOUT=16).
module tb_ds_link_dir_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       ibuf_en;
    logic       ibuf_o;
    logic       obuf_t;
    logic       obuf_i;
`ifdef DS_LINK_PARITY_EN
    logic       rx_perr;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    ds_link_dir_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
`ifdef DS_LINK_PARITY_EN
        .rx_perr (rx_perr),
`endif
        .ibuf_en (ibuf_en),
        .ibuf_o  (ibuf_o),
        .obuf_t  (obuf_t),
        .obuf_i  (obuf_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Buffer exclusivity, checked away from the active edge every cycle.
    always @(negedge clk) begin
        check("excl", {31'd0, obuf_t & ibuf_en}, 32'd0);
    end

    initial begin
        logic [7:0] pat;
        rst      = 1'b1;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        ibuf_o   = 1'b0;
        tick();
        tick();
        check("rst_ibuf_en", ibuf_en, 1);
        check("rst_obuf_t", obuf_t, 0);
        check("rst_obuf_i", obuf_i, 0);
        check("rst_tx_ready", tx_ready, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        rst = 1'b0;

        // Idle line: listening, nothing received.
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_rx_valid", rx_valid, 0);
            check("idle_ibuf_en", ibuf_en, 1);
            check("idle_obuf_t", obuf_t, 0);
        end

        // Receive 8'hA5.
        pat = 8'hA5;
        ibuf_o = 1'b1;
        tick();
        check("a5_start_valid", rx_valid, 0);
        for (int i = 0; i < 8; i++) begin
            ibuf_o = pat[i];
            tick();
            if (i < 7) check("a5_early_valid", rx_valid, 0);
            else       check("a5_valid", rx_valid, 1);
        end
        check("a5_data", rx_data, 32'hA5);
        ibuf_o = 1'b0;
        tick();
        check("a5_pulse_end", rx_valid, 0);
        check("a5_data_hold", rx_data, 32'hA5);

        // Transmit 8'h3C: two turnaround cycles, ready on the third.
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("tt_ibuf_en", ibuf_en, 0);
            check("tt_obuf_t", obuf_t, 0);
            check("tt_tx_ready", tx_ready, 0);
        end
        tick();
        check("hold_tx_ready", tx_ready, 1);
        check("hold_obuf_t", obuf_t, 1);
        check("hold_obuf_i", obuf_i, 0);
        tick();
        tx_valid = 1'b0;
        check("3c_start", obuf_i, 1);
        check("3c_ready_low", tx_ready, 0);
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("3c_bit", obuf_i, {31'd0, pat[i]});
            check("3c_obuf_t", obuf_t, 1);
        end
        tick();
        check("3c_back_hold", tx_ready, 1);
        check("3c_idle_level", obuf_i, 0);

        // Back-to-back 8'h01 then 8'hFF.
        tx_data  = 8'h01;
        tx_valid = 1'b1;
        tick();
        check("b1_start", obuf_i, 1);
        tx_data = 8'hFF;
        pat = 8'h01;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("b1_bit", obuf_i, {31'd0, pat[i]});
            check("b1_obuf_t", obuf_t, 1);
        end
        tick();
        check("b1_hold_ready", tx_ready, 1);
        check("b1_hold_obuf_t", obuf_t, 1);
        check("b1_hold_obuf_i", obuf_i, 0);
        tick();
        check("b2_start_at_10", obuf_i, 1);
        check("b2_obuf_t", obuf_t, 1);
        tx_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("b2_bit", obuf_i, 1);
        end
        tick();
        check("b2_hold_ready", tx_ready, 1);

        // Idle timeout: 16 cycles in hold, 2 turnaround, then receive.
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_hold_ready", tx_ready, 1);
            check("to_hold_obuf_t", obuf_t, 1);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            check("tr_tx_ready", tx_ready, 0);
            check("tr_obuf_t", obuf_t, 0);
            check("tr_ibuf_en", ibuf_en, 0);
        end
        tick();
        check("to_back_rx", ibuf_en, 1);
        check("to_back_obuf_t", obuf_t, 0);

        // tx_valid arrives mid-frame: frame 8'hC3 completes first.
        pat = 8'hC3;
        tick();
        ibuf_o = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            ibuf_o = pat[i];
            if (i == 4) begin
                tx_data  = 8'h96;
                tx_valid = 1'b1;
            end
            tick();
            check("mid_ibuf_en", ibuf_en, 1);
        end
        check("mid_valid", rx_valid, 1);
        check("mid_data", rx_data, 32'hC3);
        ibuf_o = 1'b0;
        tick();
        check("mid_turn_ibuf_en", ibuf_en, 0);
        check("mid_turn_valid", rx_valid, 0);
        tick();
        tick();
        check("mid_hold_ready", tx_ready, 1);
        tick();
        check("mid_start", obuf_i, 1);
        tick();
        tick();
        tick();
        check("mid_shift_obuf_t", obuf_t, 1);
        // Reset in the middle of the TX shift.
        rst = 1'b1;
        tick();
        check("txrst_obuf_t", obuf_t, 0);
        check("txrst_ibuf_en", ibuf_en, 1);
        check("txrst_obuf_i", obuf_i, 0);
        check("txrst_tx_ready", tx_ready, 0);
        check("txrst_rx_valid", rx_valid, 0);
        check("txrst_rx_data", rx_data, 0);
        rst      = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("post_txrst_valid", rx_valid, 0);
            check("post_txrst_obuf_t", obuf_t, 0);
            check("post_txrst_ibuf_en", ibuf_en, 1);
        end

        // Reset in the middle of an RX frame discards it.
        ibuf_o = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        ibuf_o = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("rxrst_no_valid", rx_valid, 0);
        end
        check("rxrst_data", rx_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
